// File: rtl/trap_pkg.sv
// Shared types and constants for the commit-stage trap monitor.
// Pure declarations: no logic, no latency, no flow control.
package trap_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_GOOD     = 3'd1,
    CAUSE_BAD_EXIT = 3'd2,
    CAUSE_ILLEGAL  = 3'd3,
    CAUSE_OVERFLOW = 3'd4,
    CAUSE_TIMEOUT  = 3'd5
  } cause_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [31:0] EBREAK_INST = 32'h00100073;
  localparam logic [6:0]  BAD_OPCODE  = 7'h7F;

endpackage

// File: rtl/trap_chan_decode.sv
// Per-channel trap classifier: illegal opcode beats overflow beats ebreak.
// Purely combinational, zero latency; never stalls the commit channel.
module trap_chan_decode
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            valid,
  input  logic [XLEN-1:0] inst,
  input  logic            ovf,
  input  logic [XLEN-1:0] a0,
  output logic            trap_hit,
  output cause_t          trap_cause
);

  logic [31:0] iw;
  assign iw = inst[31:0];

  always_comb begin
    trap_hit   = 1'b0;
    trap_cause = CAUSE_NONE;
    if (valid) begin
      if (iw[6:0] == BAD_OPCODE) begin
        trap_hit   = 1'b1;
        trap_cause = CAUSE_ILLEGAL;
      end else if (ovf) begin
        trap_hit   = 1'b1;
        trap_cause = CAUSE_OVERFLOW;
      end else if (iw == EBREAK_INST) begin
        trap_hit   = 1'b1;
        trap_cause = (a0 == '0) ? CAUSE_GOOD : CAUSE_BAD_EXIT;
      end
    end
  end

endmodule

// File: rtl/trap_monitor.sv
// NCH-wide commit trap monitor with optional commit watchdog (TRAP_WATCHDOG_EN).
// All outputs registered: stop one cycle after detection, done DRAIN_CYCLES later; commits are never back-pressured.
module trap_monitor
  import trap_pkg::*;
#(
  parameter int NCH          = 1,
  parameter int XLEN         = 32,
  parameter int DRAIN_CYCLES = 2,
  parameter int WDOG_W       = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      commit_valid,
  input  logic [NCH*XLEN-1:0] commit_pc,
  input  logic [NCH*XLEN-1:0] commit_inst,
  input  logic [NCH-1:0]      commit_ovf,
  input  logic [XLEN-1:0]     a0,
  output logic                stop,
  output logic                done,
  output logic [2:0]          cause,
  output logic [XLEN-1:0]     trap_pc,
  output logic [XLEN-1:0]     exit_code,
  output logic [63:0]         inst_count,
  output logic [63:0]         cycle_count
);

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  if (NCH < 1 || NCH > 4 || DRAIN_CYCLES < 0 || DRAIN_CYCLES > 15 || WDOG_W < 1 || XLEN < 32)
  begin : g_param_check
    $error("trap_monitor: unsupported parameter combination");
  end

  state_t          state, state_nxt;
  logic [3:0]      drain_cnt, drain_cnt_nxt;
  logic            done_nxt;
  cause_t          cause_q;

  logic   [NCH-1:0] ch_hit;
  cause_t           ch_cause [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    trap_chan_decode #(.XLEN(XLEN)) u_dec (
      .valid      (commit_valid[g]),
      .inst       (commit_inst[g*XLEN +: XLEN]),
      .ovf        (commit_ovf[g]),
      .a0         (a0),
      .trap_hit   (ch_hit[g]),
      .trap_cause (ch_cause[g])
    );
  end

  // Lowest trapping channel wins; only valid channels up to it retire.
  logic            hit_any;
  cause_t          win_cause;
  logic [XLEN-1:0] win_pc, win_code;
  logic [63:0]     n_ret;
`ifdef TRAP_WATCHDOG_EN
  logic [XLEN-1:0] ret_pc;
`endif

  always_comb begin
    hit_any   = 1'b0;
    win_cause = CAUSE_NONE;
    win_pc    = '0;
    n_ret     = '0;
`ifdef TRAP_WATCHDOG_EN
    ret_pc    = '0;
`endif
    for (int i = 0; i < NCH; i++) begin
      if (!hit_any && commit_valid[i]) begin
        n_ret = n_ret + 64'd1;
`ifdef TRAP_WATCHDOG_EN
        ret_pc = commit_pc[i*XLEN +: XLEN];
`endif
        if (ch_hit[i]) begin
          hit_any   = 1'b1;
          win_cause = ch_cause[i];
          win_pc    = commit_pc[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign win_code = (win_cause == CAUSE_GOOD || win_cause == CAUSE_BAD_EXIT) ? a0 : '0;

  logic            trap_fire;
  cause_t          fire_cause;
  logic [XLEN-1:0] fire_pc, fire_code;

`ifdef TRAP_WATCHDOG_EN
  logic [WDOG_W-1:0] wdog_q, wdog_nxt;
  logic [XLEN-1:0]   last_pc;
  logic              timeout;

  assign wdog_nxt = (|commit_valid) ? '0 : wdog_q + WDOG_W'(1);
  assign timeout  = (wdog_nxt == '1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_q  <= '0;
      last_pc <= '0;
    end else if (state == ST_RUN) begin
      wdog_q <= wdog_nxt;
      if (|commit_valid) last_pc <= ret_pc;
    end
  end

  // A real trap in the same cycle outranks the timeout.
  assign trap_fire  = hit_any | timeout;
  assign fire_cause = hit_any ? win_cause : CAUSE_TIMEOUT;
  assign fire_pc    = hit_any ? win_pc : last_pc;
  assign fire_code  = hit_any ? win_code : '0;
`else
  assign trap_fire  = hit_any;
  assign fire_cause = win_cause;
  assign fire_pc    = win_pc;
  assign fire_code  = win_code;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    done_nxt      = 1'b0;
    case (state)
      ST_RUN: begin
        if (trap_fire) begin
          drain_cnt_nxt = '0;
          if (DRAIN_CYCLES == 0) begin
            state_nxt = ST_HALTED;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = ST_HALTED;
          done_nxt  = 1'b1;
        end else begin
          drain_cnt_nxt = drain_cnt + 4'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stop        <= 1'b0;
      done        <= 1'b0;
      cause_q     <= CAUSE_NONE;
      trap_pc     <= '0;
      exit_code   <= '0;
      inst_count  <= '0;
      cycle_count <= '0;
    end else begin
      done <= done_nxt;
      if (state == ST_RUN) begin
        cycle_count <= cycle_count + 64'd1;
        inst_count  <= inst_count + n_ret;
        if (trap_fire) begin
          stop      <= 1'b1;
          cause_q   <= fire_cause;
          trap_pc   <= fire_pc;
          exit_code <= fire_code;
        end
      end
    end
  end

  assign cause = cause_q;

endmodule

// File: tb/tb_trap_monitor.sv
// Directed scoreboard bench for trap_monitor (NCH=2, DRAIN_CYCLES=2, watchdog build off).
module tb_trap_monitor;
  localparam int NCH  = 2;
  localparam int XLEN = 32;
  localparam int DC   = 2;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] EBRK = 32'h00100073;
  localparam logic [31:0] ILL  = 32'h0000007F;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NCH-1:0]      commit_valid = '0;
  logic [NCH*XLEN-1:0] commit_pc = '0;
  logic [NCH*XLEN-1:0] commit_inst = '0;
  logic [NCH-1:0]      commit_ovf = '0;
  logic [XLEN-1:0]     a0 = '0;
  logic                stop, done;
  logic [2:0]          cause;
  logic [XLEN-1:0]     trap_pc, exit_code;
  logic [63:0]         inst_count, cycle_count;

  trap_monitor #(.NCH(NCH), .XLEN(XLEN), .DRAIN_CYCLES(DC), .WDOG_W(20)) dut (
    .clk(clk), .rst(rst), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .commit_ovf(commit_ovf), .a0(a0), .stop(stop),
    .done(done), .cause(cause), .trap_pc(trap_pc), .exit_code(exit_code),
    .inst_count(inst_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  cause;
    logic [31:0] pc;
    logic [31:0] code;
    logic [63:0] ic;
    logic [63:0] cc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] c, input logic [31:0] pc, input logic [31:0] code,
                      input logic [63:0] ic, input logic [63:0] cc);
    exp_t e;
    e.cause = c; e.pc = pc; e.code = code; e.ic = ic; e.cc = cc;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [1:0] v, input logic [31:0] p0, input logic [31:0] i0,
                       input logic o0, input logic [31:0] p1, input logic [31:0] i1,
                       input logic o1, input logic [31:0] a);
    commit_valid = v;
    commit_pc    = {p1, p0};
    commit_inst  = {i1, i0};
    commit_ovf   = {o1, o0};
    a0           = a;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    commit_valid = '0;
    commit_ovf   = '0;
    commit_inst  = '0;
    a0           = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stop"}, 64'(stop), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_cause"}, 64'(cause), 64'd0);
    chk({tag, "_pc"}, 64'(trap_pc), 64'd0);
    chk({tag, "_code"}, 64'(exit_code), 64'd0);
    chk({tag, "_ic"}, inst_count, 64'd0);
    chk({tag, "_cc"}, cycle_count, 64'd0);
  endtask

  // Hold reset across two edges, then release just after a rising edge.
  task automatic do_reset(input string tag);
    idle();
    rst = 1'b0;
    #1;
    chk_zero(tag);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Called just after the edge that ends the detection cycle.
  task automatic arrive_trap(input string tag);
    exp_t e;
    idle();
    @(negedge clk);
    chk({tag, "_stop"}, 64'(stop), 64'd1);
    chk({tag, "_done_early"}, 64'(done), 64'd0);
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_cause"}, 64'(cause), 64'(e.cause));
      chk({tag, "_pc"}, 64'(trap_pc), 64'(e.pc));
      chk({tag, "_code"}, 64'(exit_code), 64'(e.code));
      chk({tag, "_ic"}, inst_count, e.ic);
      chk({tag, "_cc"}, cycle_count, e.cc);
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_lat"}, 64'(n), 64'(DC));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    // Scenario 1: ten plain commits then a good ebreak.
    do_reset("rst1");
    for (int k = 0; k < 10; k++)
      drive(2'b01, 32'h80000000 + 32'(4 * k), NOP, 1'b0, 32'h0, NOP, 1'b0, 32'h0);
    push(3'd1, 32'h80000028, 32'h0, 64'd11, 64'd11);
    drive(2'b01, 32'h80000028, EBRK, 1'b0, 32'h0, NOP, 1'b0, 32'h0);
    arrive_trap("good");
    wait_done("good");
    drive(2'b11, 32'h200, NOP, 1'b0, 32'h204, ILL, 1'b0, 32'h0);
    drive(2'b11, 32'h208, EBRK, 1'b0, 32'h20C, NOP, 1'b1, 32'h7);
    @(negedge clk);
    chk("halted_ic", inst_count, 64'd11);
    chk("halted_cc", cycle_count, 64'd11);
    chk("halted_cause", 64'(cause), 64'd1);
    chk("halted_done", 64'(done), 64'd0);

    // Scenario 2: bad exit; ch1 beside the ebreak is not counted.
    do_reset("rst2");
    drive(2'b11, 32'h1000, NOP, 1'b0, 32'h1004, NOP, 1'b0, 32'h0);
    drive(2'b11, 32'h1008, NOP, 1'b0, 32'h100C, NOP, 1'b0, 32'h0);
    push(3'd2, 32'h1010, 32'h2A, 64'd5, 64'd3);
    drive(2'b11, 32'h1010, EBRK, 1'b0, 32'h1014, NOP, 1'b0, 32'h2A);
    arrive_trap("bad");
    wait_done("bad");

    // Scenario 3: illegal on ch1, then reset in the middle of draining.
    do_reset("rst3");
    push(3'd3, 32'h104, 32'h0, 64'd2, 64'd1);
    drive(2'b11, 32'h100, NOP, 1'b0, 32'h104, ILL, 1'b0, 32'h5);
    arrive_trap("ill_ch1");
    #1;
    rst = 1'b0;
    #1;
    chk_zero("mid_drain");
    repeat (3) begin
      @(negedge clk);
      chk("mid_drain_no_done", 64'(done), 64'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Scenario 4: ebreak on ch0 outranks illegal on ch1.
    push(3'd1, 32'h300, 32'h0, 64'd1, 64'd1);
    drive(2'b11, 32'h300, EBRK, 1'b0, 32'h304, ILL, 1'b0, 32'h0);
    arrive_trap("ch0_wins");
    wait_done("ch0_wins");

    // Scenario 5: overflow ignored without valid, then overflow on an ebreak word.
    do_reset("rst5");
    drive(2'b00, 32'h400, EBRK, 1'b1, 32'h404, NOP, 1'b1, 32'h0);
    @(negedge clk);
    chk("ovf_novalid_stop", 64'(stop), 64'd0);
    chk("ovf_novalid_ic", inst_count, 64'd0);
    push(3'd4, 32'h408, 32'h0, 64'd1, 64'd2);
    drive(2'b01, 32'h408, EBRK, 1'b1, 32'h40C, NOP, 1'b0, 32'h9);
    arrive_trap("ovf");
    wait_done("ovf");

    // Scenario 6: illegal opcode outranks overflow on the same channel.
    do_reset("rst6");
    push(3'd3, 32'h500, 32'h0, 64'd1, 64'd1);
    drive(2'b01, 32'h500, ILL, 1'b1, 32'h504, NOP, 1'b0, 32'h0);
    arrive_trap("ill_vs_ovf");
    wait_done("ill_vs_ovf");

    // Scenario 7: long idle never stops (no watchdog), then bad exit on ch1 only.
    do_reset("rst7");
    repeat (100) drive(2'b00, 32'h0, NOP, 1'b0, 32'h0, NOP, 1'b0, 32'h0);
    @(negedge clk);
    chk("idle_stop", 64'(stop), 64'd0);
    chk("idle_cc", cycle_count, 64'd100);
    chk("idle_ic", inst_count, 64'd0);
    push(3'd2, 32'h604, 32'h5, 64'd1, 64'd101);
    drive(2'b10, 32'h600, ILL, 1'b0, 32'h604, EBRK, 1'b0, 32'h5);
    arrive_trap("ch1_only");
    wait_done("ch1_only");

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_monitor.md
# trap_monitor

Parametrised simulation and bring-up trap monitor for the NPC core. It watches up to NCH retiring instructions per cycle and detects ebreak (good or bad exit via a0), illegal opcodes, arithmetic overflow and, optionally, a commit watchdog timeout. On a trap it freezes the core, drains for a fixed number of cycles, then reports cause, PC, exit code and retirement statistics. It sits beside the commit stage and replaces single-channel, purely combinational trap detection.

## Interface
Parameters:
- NCH, 1: commit channels per cycle (1–4).
- XLEN, 32: PC, instruction and a0 width.
- DRAIN_CYCLES, 2: cycles between `stop` and `done` (0–15).
- WDOG_W, 20: watchdog counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- commit_valid  in  NCH  channel i retires an instruction this cycle.
- commit_pc  in  NCH*XLEN  PC for channel i, in slice [i*XLEN +: XLEN].
- commit_inst  in  NCH*XLEN  instruction word for channel i.
- commit_ovf  in  NCH  overflow flag for channel i.
- a0  in  XLEN  architectural x10, valid together with the commit it accompanies.
- stop  out  1  freeze request to the core; sticky.
- done  out  1  one-cycle pulse when draining completes.
- cause  out  3  0 NONE, 1 GOOD, 2 BAD_EXIT, 3 ILLEGAL, 4 OVERFLOW, 5 TIMEOUT.
- trap_pc  out  XLEN  PC of the trapping instruction.
- exit_code  out  XLEN  a0 captured at ebreak; 0 for other causes.
- inst_count  out  64  retired instructions.
- cycle_count  out  64  cycles spent in RUN.

## Operation
FSM states: RUN, DRAIN, HALTED.

- **RUN**
  - Channels are scanned from index 0 upward. The first valid channel that traps wins. Channels above it are ignored and not counted.
  - Per-channel priority: ILLEGAL (inst[6:0] == 7'h7F), then OVERFLOW (commit_ovf), then ebreak (inst == 32'h00100073).
  - An ebreak gives GOOD if a0 == 0, otherwise BAD_EXIT.
  - inst_count adds the number of valid channels up to and including the trapping one. With no trap, it adds popcount(commit_valid).
  - cycle_count increments every RUN cycle, including the detection cycle.
- **Trap**
  - Latch cause, trap_pc and exit_code. Set `stop`.
  - Go to DRAIN, or to HALTED directly if DRAIN_CYCLES == 0.
- **DRAIN**
  - A 4-bit counter counts DRAIN_CYCLES cycles.
  - All commit inputs are ignored and the counters are frozen.
- **HALTED**
  - Entered with `done` = 1 for exactly one cycle.
  - The monitor stays here until reset and ignores all inputs.
- **Reset**
  - Applies immediately, including mid-DRAIN, and returns the FSM to RUN.
  - All outputs reset to 0: stop, done, cause (NONE), trap_pc, exit_code, inst_count, cycle_count.
- **Widths**
  - The counters wrap modulo 2^64; no saturation.
  - Opcode and ebreak compares use the low 32 bits of inst when XLEN > 32.

## Timing
- Detection in cycle T, sampled at the edge ending T.
  - At T+1: `stop` = 1, and cause, trap_pc, exit_code and the counters hold their final values.
  - `done` pulses at T+1+DRAIN_CYCLES.
- All outputs are registered; there are no combinational input-to-output paths.
- When a trap and further valid commits arrive in the same cycle, the lowest trapping channel wins deterministically.

## Configuration
- **TRAP_WATCHDOG_EN defined**
  - A WDOG_W-bit counter clears on any cycle in RUN with a nonzero commit_valid and increments otherwise.
  - When it reaches all-ones in RUN, the monitor traps with cause TIMEOUT, trap_pc = PC of the last retired instruction (0 if none) and exit_code = 0.
  - A real trap in the same cycle takes precedence.
- **Undefined**
  - No watchdog logic; TIMEOUT is never produced.

## Structure
- Shared package `trap_pkg` holds:
  - the cause enum with its 3-bit encoding;
  - the FSM state enum;
  - the constants EBREAK_INST = 32'h00100073 and BAD_OPCODE = 7'h7F.
- Sub-module `trap_chan_decode` (combinational, one instance per channel): takes valid, inst, ovf and a0 and produces trap_hit and its cause. The top level does the priority scan, FSM, counters and watchdog.

## Test plan
- NCH=1, DRAIN_CYCLES=2, 10 plain commits, then ebreak at PC 0x80000028 with a0=0 -> stop at T+1, cause=1, trap_pc=0x80000028, inst_count=11, done pulses once at T+3.
- ebreak with a0=0x2A -> cause=2, exit_code=0x2A.
- NCH=2; cycle with ch0 plain, ch1 inst[6:0]=7'h7F -> cause=3, trap_pc=ch1 PC, inst_count +2. In a separate cycle with ch0 ebreak and ch1 illegal -> cause=1 (ch0 wins), inst_count +1.
- Overflow on a valid ebreak word -> cause=4. Overflow with valid=0 -> no trap.
- Reset asserted mid-DRAIN, then released -> all outputs 0, FSM in RUN, a later ebreak traps normally.
- TRAP_WATCHDOG_EN, WDOG_W=4, last commit at PC 0x100, then idle -> TIMEOUT after 15 idle cycles with trap_pc=0x100. Without the macro, 100 idle cycles -> no stop.
